// File: rtl/mmio_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets inside the 8-byte address window
//   - STATUS word bit positions
//   - transmitter FSM state encoding (PARITY is always present so the
//     encoding does not shift when the parity build option changes)
//   - even-parity helper
// -----------------------------------------------------------------------------
package mmio_uart_tx_pkg;

   // Register offsets inside the window (addr[2] selects between them)
   localparam logic [2:0] UART_TXDATA_OFS = 3'd0;
   localparam logic [2:0] UART_STATUS_OFS = 3'd4;

   // STATUS word layout
   localparam int unsigned STATUS_FULL_BIT  = 0;
   localparam int unsigned STATUS_EMPTY_BIT = 1;
   localparam int unsigned STATUS_BUSY_BIT  = 2;
   localparam int unsigned STATUS_OVF_BIT   = 3;
   localparam int unsigned STATUS_COUNT_LSB = 4;
   localparam int unsigned STATUS_COUNT_W   = 5;

   // Transmitter FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Even parity: the bit that makes the total number of ones even
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage : mmio_uart_tx_pkg

// File: rtl/mmio_uart_tx_if.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_if
// CPU data-memory port as seen by the UART transmitter.
//   write_en   : store strobe (CPU -> peripheral)
//   addr       : data address (CPU -> peripheral)
//   write_data : store data, only [7:0] meaningful (CPU -> peripheral)
//   read_data  : combinational status or zero (peripheral -> CPU)
// Modports: master = CPU side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface mmio_uart_tx_if;
   import mmio_uart_tx_pkg::*;

   logic        write_en;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (
      output write_en,
      output addr,
      output write_data,
      input  read_data
   );

   modport slave (
      input  write_en,
      input  addr,
      input  write_data,
      output read_data
   );

endinterface : mmio_uart_tx_if

// File: rtl/mmio_uart_tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous active-high reset.
//   clk, reset : clock and synchronous reset shared with the parent
//   push/wdata : write request and data (ignored when full unless popping)
//   pop/rdata  : read request; rdata shows the head entry combinationally
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
// A push and a pop in the same cycle both take effect; when full the pop
// frees the slot the push writes into, and rdata still returns the old head.
// -----------------------------------------------------------------------------
module sync_fifo
   import mmio_uart_tx_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push_s;
   logic             do_pop_s;

   // Occupancy flags and qualified push/pop
   always_comb begin
      full      = (count_q == CW'(DEPTH));
      empty     = (count_q == {CW{1'b0}});
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      rdata     = mem_q[rd_ptr_q];
      count     = count_q;
   end

   // Next pointer and count values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule : sync_fifo

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter (8N1) on the CPU data-memory port.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   bus    : mmio_uart_tx_if.slave (write_en, addr, write_data, read_data)
//   tx     : serial output, idle high (registered)
//   busy   : frame on the wire or FIFO non-empty (registered)
// Window: addr[31:3] == BASE_ADDR[31:3]; addr[2] selects TXDATA (0) or
// STATUS (4); addr[1:0] ignored.
// Build option: define MMIO_UART_TX_PARITY_EN to append an even-parity bit
// after data bit 7 (frame becomes 11 bit times instead of 10).
// -----------------------------------------------------------------------------
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic          clk,
   input  logic          reset,
   mmio_uart_tx_if.slave bus,
   output logic          tx,
   output logic          busy
);

   localparam int unsigned TIMER_W = $clog2(CLK_DIV);
   localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

   uart_state_e          state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [7:0]           shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 overflow_q, overflow_d;
`ifdef MMIO_UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   logic                 hit_s;
   logic                 is_status_s;
   logic                 store_data_s;
   logic                 store_status_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 timer_end_s;
   logic [31:0]          status_s;
   logic [7:0]           fifo_rdata_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic [CW-1:0]        fifo_count_s;
   logic [CW-1:0]        fifo_count_next_s;
   logic                 unused_bits_s;

   // Byte-lane and sub-word address bits carry no information here
   assign unused_bits_s = ^{bus.addr[1:0], bus.write_data[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .wdata (bus.write_data[7:0]),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Address decode and store qualification
   always_comb begin
      hit_s          = (bus.addr[31:3] == BASE_ADDR[31:3]);
      is_status_s    = (bus.addr[2] == UART_STATUS_OFS[2]);
      store_data_s   = bus.write_en && hit_s && !is_status_s;
      store_status_s = bus.write_en && hit_s && is_status_s;
      // A pop in the same cycle frees a slot, so a store to a full FIFO lands
      push_s         = store_data_s && (!fifo_full_s || pop_s);
      timer_end_s    = (timer_q == TIMER_W'(CLK_DIV - 1));
   end

   // STATUS word and load-data mux (zero latency, independent of write_en)
   always_comb begin
      status_s = 32'h0000_0000;
      status_s[STATUS_FULL_BIT]  = fifo_full_s;
      status_s[STATUS_EMPTY_BIT] = fifo_empty_s;
      status_s[STATUS_BUSY_BIT]  = busy_q;
      status_s[STATUS_OVF_BIT]   = overflow_q;
      status_s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count_s);
      if (hit_s && is_status_s) begin
         bus.read_data = status_s;
      end else begin
         bus.read_data = 32'h0000_0000;
      end
   end

   // Sticky overflow: set by a dropped byte, cleared by any STATUS store
   always_comb begin
      overflow_d = overflow_q;
      if (store_status_s) begin
         overflow_d = 1'b0;
      end else if (store_data_s && fifo_full_s && !pop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // FIFO occupancy after this edge, so busy can be registered without lag
   always_comb begin
      fifo_count_next_s = fifo_count_s;
      if (push_s && !pop_s) begin
         fifo_count_next_s = fifo_count_s + CW'(1);
      end else if (pop_s && !push_s) begin
         fifo_count_next_s = fifo_count_s - CW'(1);
      end else begin
         fifo_count_next_s = fifo_count_s;
      end
      busy_d = (state_d != ST_IDLE) || (fifo_count_next_s != {CW{1'b0}});
   end

`ifdef MMIO_UART_TX_PARITY_EN
   // Parity of the byte is captured when it leaves the FIFO
   always_comb begin
      parity_d = parity_q;
      if (pop_s) begin
         parity_d = even_parity(fifo_rdata_s);
      end else begin
         parity_d = parity_q;
      end
   end
`endif

   // Transmitter FSM: next state, bit timer, shifter and next tx level
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = {TIMER_W{1'b0}};
            if (!fifo_empty_s) begin
               pop_s     = 1'b1;
               shift_d   = fifo_rdata_s;
               bit_idx_d = 3'd0;
               tx_d      = 1'b0;
               state_d   = ST_START;
            end else begin
               tx_d = 1'b1;
            end
         end
         ST_START: begin
            if (timer_end_s) begin
               timer_d = {TIMER_W{1'b0}};
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_DATA: begin
            if (timer_end_s) begin
               timer_d = {TIMER_W{1'b0}};
               if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  // Shifter always holds the current bit in [0]
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_PARITY: begin
`ifdef MMIO_UART_TX_PARITY_EN
            if (timer_end_s) begin
               timer_d = {TIMER_W{1'b0}};
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
`else
            // Unreachable without the parity option; recover to idle
            timer_d = {TIMER_W{1'b0}};
            tx_d    = 1'b1;
            state_d = ST_IDLE;
`endif
         end
         ST_STOP: begin
            if (timer_end_s) begin
               timer_d = {TIMER_W{1'b0}};
               if (!fifo_empty_s) begin
                  // Chain straight into the next start bit, no idle gap
                  pop_s     = 1'b1;
                  shift_d   = fifo_rdata_s;
                  bit_idx_d = 3'd0;
                  tx_d      = 1'b0;
                  state_d   = ST_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: begin
            timer_d = {TIMER_W{1'b0}};
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         timer_q    <= {TIMER_W{1'b0}};
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef MMIO_UART_TX_PARITY_EN
   // Parity register
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign tx   = tx_q;
   assign busy = busy_q;

endmodule : mmio_uart_tx

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
// The expected serial waveform is generated from the byte list and the
// frame format; tx/busy are captured on every falling edge and compared.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEPTH   = 4;
   localparam logic [31:0] BASE    = 32'h1000_0000;
`ifdef MMIO_UART_TX_PARITY_EN
   localparam int SEGS = 11;
`else
   localparam int SEGS = 10;
`endif
   localparam int FRAME = SEGS * CLK_DIV;

   logic clk;
   logic reset;
   logic tx;
   logic busy;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .tx    (tx),
      .busy  (busy)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        cap_on   = 1'b0;
   logic        cap_tx[$];
   logic        cap_busy[$];
   logic        exp_tx[$];
   logic        exp_busy[$];
   logic [7:0]  sent_q[$];
   logic [31:0] rd_status;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture line state once per cycle, away from the rising edge
   always @(negedge clk) begin
      if (cap_on) begin
         cap_tx.push_back(tx);
         cap_busy.push_back(busy);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Level of segment 'seg' of a frame carrying byte b
   function automatic logic frame_bit(input logic [7:0] b, input int seg);
      if (seg == 0) return 1'b0;
      else if (seg <= 8) return b[seg-1];
`ifdef MMIO_UART_TX_PARITY_EN
      else if (seg == 9) return ^b;
`endif
      else return 1'b1;
   endfunction

   // STATUS word from model occupancy / busy / overflow
   function automatic logic [31:0] status_word(input int occ, input logic bsy, input logic ovf);
      logic [31:0] w;
      w      = 32'h0;
      w[0]   = (occ == DEPTH);
      w[1]   = (occ == 0);
      w[2]   = bsy;
      w[3]   = ovf;
      w[8:4] = 5'(occ);
      return w;
   endfunction

   // Expected per-cycle tx/busy, first sample = cycle right after first store
   task automatic build_expect();
      int total;
      exp_tx.delete();
      exp_busy.delete();
      total = sent_q.size() * FRAME;
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b1);
      for (int j = 0; j < total; j++) begin
         exp_tx.push_back(frame_bit(sent_q[j / FRAME], (j % FRAME) / CLK_DIV));
         exp_busy.push_back(1'b1);
      end
      for (int j = 0; j < 2 * CLK_DIV; j++) begin
         exp_tx.push_back(1'b1);
         exp_busy.push_back(1'b0);
      end
   endtask

   // One CPU store; afterwards addr points at STATUS and rd_status holds it
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.addr       = a;
      bus.write_data = d;
      bus.write_en   = 1'b1;
      @(posedge clk);
      #1;
      bus.write_en   = 1'b0;
      bus.write_data = 32'h0;
      bus.addr       = BASE + 32'd4;
      #1;
      rd_status = bus.read_data;
   endtask

   task automatic wait_capture();
      for (int w = 0; w < exp_tx.size() + 16; w++) begin
         if (cap_tx.size() >= exp_tx.size()) break;
         @(posedge clk);
      end
      @(posedge clk);
      #1;
      cap_on = 1'b0;
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      bus.write_en   = 1'b0;
      bus.addr       = BASE + 32'd4;
      bus.write_data = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.read_data !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL reset_status: got %h want %h", bus.read_data, 32'h0000_0002);
      end
      n_checks++;
      if (tx !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_tx: got %b want 1", tx);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      bus.addr = BASE;
      #1;
      n_checks++;
      if (bus.read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL txdata_read: got %h want 0", bus.read_data);
      end
      bus.addr = BASE + 32'd4;
   endtask

   // Single A5 frame, then random bursts of 1..3 bytes
   task automatic test_frames();
      for (int r = 0; r < 4; r++) begin
         int n;
         n = (r == 0) ? 1 : int'($urandom_range(1, 3));
         sent_q.delete();
         cap_tx.delete();
         cap_busy.delete();
         for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = (r == 0) ? 8'hA5 : 8'($urandom);
            sent_q.push_back(b);
            // upper data bits and addr[1:0] must be ignored
            store(BASE + 32'($urandom_range(0, 3)), {24'($urandom), b});
            if (i == 0) cap_on = 1'b1;
         end
         build_expect();
         wait_capture();
         for (int j = 0; j < exp_tx.size(); j++) begin
            n_checks++;
            if (j >= cap_tx.size() || cap_tx[j] !== exp_tx[j] || cap_busy[j] !== exp_busy[j]) begin
               n_fail++;
               $display("FAIL frames_r%0d_cyc%0d: got tx=%b busy=%b want tx=%b busy=%b", r, j,
                        (j < cap_tx.size()) ? cap_tx[j] : 1'bx,
                        (j < cap_busy.size()) ? cap_busy[j] : 1'bx, exp_tx[j], exp_busy[j]);
            end
         end
      end
   endtask

   // Six stores in consecutive cycles into a 4-deep FIFO
   task automatic test_back_to_back();
      int   occ;
      logic ovf;
      occ = 0;
      ovf = 1'b0;
      sent_q.delete();
      cap_tx.delete();
      cap_busy.delete();
      for (int i = 0; i < 6; i++) begin
         logic [7:0] b;
         logic       pop;
         b   = 8'($urandom);
         pop = (i == 1);   // first byte leaves the FIFO one edge after it arrives
         if (occ == DEPTH && !pop) ovf = 1'b1;
         else begin
            sent_q.push_back(b);
            occ++;
         end
         if (pop) occ--;
         store(BASE, {24'h0, b});
         if (i == 0) cap_on = 1'b1;
         if (i >= 4) begin
            n_checks++;
            if (rd_status !== status_word(occ, 1'b1, ovf)) begin
               n_fail++;
               $display("FAIL b2b_status_store%0d: got %h want %h", i + 1, rd_status,
                        status_word(occ, 1'b1, ovf));
            end
         end
      end
      build_expect();
      wait_capture();
      for (int j = 0; j < exp_tx.size(); j++) begin
         n_checks++;
         if (j >= cap_tx.size() || cap_tx[j] !== exp_tx[j] || cap_busy[j] !== exp_busy[j]) begin
            n_fail++;
            $display("FAIL b2b_cyc%0d: got tx=%b busy=%b want tx=%b busy=%b", j,
                     (j < cap_tx.size()) ? cap_tx[j] : 1'bx,
                     (j < cap_busy.size()) ? cap_busy[j] : 1'bx, exp_tx[j], exp_busy[j]);
         end
      end
      n_checks++;
      if (bus.read_data !== status_word(0, 1'b0, ovf)) begin
         n_fail++;
         $display("FAIL b2b_status_drained: got %h want %h", bus.read_data, status_word(0, 1'b0, ovf));
      end
   endtask

   // Overflow, then clear it with a STATUS store while the FIFO is full
   task automatic test_overflow_clear();
      int   occ;
      logic ovf;
      logic done;
      occ = 0;
      ovf = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic pop;
         pop = (i == 1);
         if (occ == DEPTH && !pop) ovf = 1'b1;
         else occ++;
         if (pop) occ--;
         store(BASE, 32'($urandom));
      end
      n_checks++;
      if (rd_status !== status_word(occ, 1'b1, ovf)) begin
         n_fail++;
         $display("FAIL ovf_set: got %h want %h", rd_status, status_word(occ, 1'b1, ovf));
      end
      store(BASE + 32'd4, 32'($urandom));
      n_checks++;
      if (rd_status !== status_word(occ, 1'b1, 1'b0)) begin
         n_fail++;
         $display("FAIL ovf_clear: got %h want %h", rd_status, status_word(occ, 1'b1, 1'b0));
      end
      done = 1'b0;
      for (int w = 0; w < 8 * FRAME; w++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!done || bus.read_data !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL ovf_drain: got done=%b status=%h want done=1 status=%h", done,
                  bus.read_data, 32'h0000_0002);
      end
   endtask

   // Accesses outside the window are invisible
   task automatic test_window();
      logic [31:0] far;
      bus.addr = BASE + 32'd8;
      #1;
      n_checks++;
      if (bus.read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL miss_read_plus8: got %h want 0", bus.read_data);
      end
      bus.addr = BASE - 32'd4;
      #1;
      n_checks++;
      if (bus.read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL miss_read_minus4: got %h want 0", bus.read_data);
      end
      far = $urandom;
      if (far[31:3] == BASE[31:3]) far[31] = ~far[31];
      bus.addr = far;
      #1;
      n_checks++;
      if (bus.read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL miss_read_rand: got %h want 0 at %h", bus.read_data, far);
      end
      bus.addr = BASE + 32'd7;
      #1;
      n_checks++;
      if (bus.read_data !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL hit_read_low_bits: got %h want %h", bus.read_data, 32'h0000_0002);
      end
      store(BASE + 32'd8, 32'($urandom));
      store(BASE - 32'd4, 32'($urandom));
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.read_data !== 32'h0000_0002 || tx !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_store: got status=%h tx=%b busy=%b want status=%h tx=1 busy=0",
                  bus.read_data, tx, busy, 32'h0000_0002);
      end
   endtask

   // Reset during data bit 3 with two bytes still queued
   task automatic test_reset_midframe();
      logic [7:0] b0;
      logic       bad;
      b0 = 8'($urandom);
      store(BASE, {24'h0, b0});
      store(BASE, 32'($urandom));
      store(BASE, 32'($urandom));
      repeat (16) @(posedge clk);
      #1;
      n_checks++;
      if (tx !== b0[3]) begin
         n_fail++;
         $display("FAIL midframe_bit3: got %b want %b", tx, b0[3]);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || bus.read_data !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL midframe_reset: got tx=%b busy=%b status=%h want tx=1 busy=0 status=%h",
                  tx, busy, bus.read_data, 32'h0000_0002);
      end
      reset = 1'b0;
      cap_tx.delete();
      cap_busy.delete();
      cap_on = 1'b1;
      repeat (3 * FRAME) @(posedge clk);
      #1;
      cap_on = 1'b0;
      bad = (cap_tx.size() == 0);
      for (int j = 0; j < cap_tx.size(); j++) begin
         if (cap_tx[j] !== 1'b1 || cap_busy[j] !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad || bus.read_data !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL midframe_quiet: got activity=%b status=%h want activity=0 status=%h",
                  bad, bus.read_data, 32'h0000_0002);
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_back_to_back();
      test_overflow_clear();
      test_window();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mmio_uart_tx
